sobel_window_gen: RTL and testbench

Streaming producer for the combinational sobel kernel. It accepts a raster-order pixel stream and emits one 3x3 neighbourhood per accepted pixel. Ports win0..win8 are in raster order, with win4 as the centre tap, so they wire directly to the kernel's nine pixel inputs. It replaces the file-driven window feed with synthesizable line buffering between the pixel source and the kernel.

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_window_gen_if.sv | 30 +++
 rtl/sobel_line_buf.sv | 23 ++
 rtl/sobel_window_gen.sv | 115 +++++++++++
 tb/tb_sobel_window_gen.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel window generator and kernel: pixel width,
// 3x3 tap indices in raster order, and the border-masking helper.
package sobel_pkg;

  localparam int PIX_W_DEF = 9;
  localparam int WIN_TAPS  = 9;

  localparam int WIN_TL = 0;
  localparam int WIN_T  = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_L  = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_R  = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_B  = 7;
  localparam int WIN_BR = 8;

  typedef logic [WIN_TAPS-1:0][PIX_W_DEF-1:0] window_t;

  // A tap survives only if both its row and its column lie inside the frame.
  function automatic logic tap_live(input int tap, input logic top_ok, input logic mid_ok,
                                    input logic left_ok, input logic cmid_ok);
    return (tap / 3 != 0 || top_ok) && (tap / 3 != 1 || mid_ok) &&
           (tap % 3 != 0 || left_ok) && (tap % 3 != 1 || cmid_ok);
  endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle; slave is the generator's view,
// master is the pixel source plus window sink.
interface sobel_window_gen_if
  import sobel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);

  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic [PIX_W-1:0] pix_in;
  logic             win_valid;
  logic             win_ready;
  logic [PIX_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic             win_last;

  modport master (
    output pix_valid, pix_sof, pix_in, win_ready,
    input  pix_ready, win_valid, win_last,
    input  win0, win1, win2, win3, win4, win5, win6, win7, win8
  );

  modport slave (
    input  pix_valid, pix_sof, pix_in, win_ready,
    output pix_ready, win_valid, win_last,
    output win0, win1, win2, win3, win4, win5, win6, win7, win8
  );

endinterface

// File: rtl/sobel_line_buf.sv
// One row of pixel history: combinational read at addr, write of the same
// address on the clock edge, so a read-then-write happens in one cycle.
module sobel_line_buf #(
  parameter int PIX_W = 9,
  parameter int IMG_W = 512,
  parameter int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [IMG_W];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream to 3x3 window generator feeding the sobel kernel.
// Define SOBEL_WIN_INTERIOR_EN to emit only windows fully inside the frame.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input logic               clk,
  input logic               rst,
  sobel_window_gen_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, cur_col, col_nx;
  logic [RW-1:0] row_q, cur_row, row_nx;
  logic          col_end, row_end, accept, pix_ready, emit;
  logic          win_valid_q, win_last_q;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [WIN_TAPS-1:0][PIX_W-1:0] win_q, shifted, win_nx;

  assign pix_ready     = !win_valid_q || bus.win_ready;
  assign accept        = bus.pix_valid && pix_ready;
  assign bus.pix_ready = pix_ready;

  // Start-of-frame overrides the counters so the accepted pixel is (0,0).
  always_comb begin
    cur_col = bus.pix_sof ? '0 : col_q;
    cur_row = bus.pix_sof ? '0 : row_q;
    col_end = (cur_col == COL_LAST);
    row_end = (cur_row == ROW_LAST);
    col_nx  = col_end ? '0 : cur_col + 1'b1;
    row_nx  = cur_row;
    if (col_end) row_nx = row_end ? '0 : cur_row + 1'b1;
  end

  sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept && !rst),
    .addr  (cur_col),
    .wdata (bus.pix_in),
    .rdata (lb1_rd)
  );

  sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W), .AW(CW)) u_lb2 (
    .clk   (clk),
    .we    (accept && !rst),
    .addr  (cur_col),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  always_comb begin
    shifted[WIN_TL] = win_q[WIN_T];
    shifted[WIN_T]  = win_q[WIN_TR];
    shifted[WIN_TR] = lb2_rd;
    shifted[WIN_L]  = win_q[WIN_C];
    shifted[WIN_C]  = win_q[WIN_R];
    shifted[WIN_R]  = lb1_rd;
    shifted[WIN_BL] = win_q[WIN_B];
    shifted[WIN_B]  = win_q[WIN_BR];
    shifted[WIN_BR] = bus.pix_in;
  end

`ifdef SOBEL_WIN_INTERIOR_EN
  assign win_nx = shifted;
  assign emit   = (cur_row > RW'(1)) && (cur_col > CW'(1));
`else
  // Zeroed border taps also shift left as zeros, so the register stays consistent.
  always_comb begin
    win_nx = shifted;
    for (int t = 0; t < WIN_TAPS; t++) begin
      if (!tap_live(t, cur_row > RW'(1), cur_row != '0, cur_col > CW'(1), cur_col != '0))
        win_nx[t] = '0;
    end
  end
  assign emit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else if (accept) begin
      col_q       <= col_nx;
      row_q       <= row_nx;
      win_q       <= win_nx;
      win_valid_q <= emit;
      win_last_q  <= col_end && row_end;
    end else if (bus.win_ready) begin
      win_valid_q <= 1'b0;
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.win0      = win_q[WIN_TL];
  assign bus.win1      = win_q[WIN_T];
  assign bus.win2      = win_q[WIN_TR];
  assign bus.win3      = win_q[WIN_L];
  assign bus.win4      = win_q[WIN_C];
  assign bus.win5      = win_q[WIN_R];
  assign bus.win6      = win_q[WIN_BL];
  assign bus.win7      = win_q[WIN_B];
  assign bus.win8      = win_q[WIN_BR];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 frame with pixel value 10r+c+1;
// a small frame-image model supplies every expected window.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int PW = 9;
  localparam int IW = 4;
  localparam int IH = 4;

  typedef struct {
    int tap[9];
    bit last;
    int r;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.PIX_W(PW)) bus ();

  sobel_window_gen #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t q[$];
  int img[IH][IW];
  int got[IH][IW][9];
  int mr, mc;
  int nwin, nlast;
  int checks = 0;
  int passes = 0;
  int ncyc;

  int w00[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  int w10[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 11};
  int w22[9] = '{1, 2, 3, 11, 12, 13, 21, 22, 23};
  int w33[9] = '{12, 13, 14, 22, 23, 24, 32, 33, 34};
  int s00[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 13};
  int s01[9] = '{0, 0, 0, 0, 0, 0, 0, 13, 14};
  int s10[9] = '{0, 0, 0, 0, 0, 13, 0, 0, 23};
  int f01[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 2};

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  function automatic int dutTap(input int t);
    case (t)
      0: return int'(bus.win0);
      1: return int'(bus.win1);
      2: return int'(bus.win2);
      3: return int'(bus.win3);
      4: return int'(bus.win4);
      5: return int'(bus.win5);
      6: return int'(bus.win6);
      7: return int'(bus.win7);
      default: return int'(bus.win8);
    endcase
  endfunction

  task automatic checkWin(input string tag, input int r, input int c, input int exp_w[9]);
    for (int t = 0; t < 9; t++)
      checkOutput($sformatf("%s win%0d", tag, t), got[r][c][t], exp_w[t]);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_in    = '0;
    bus.win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mr = 0;
    mc = 0;
  endtask

  // One clock cycle: drive, compare at the falling edge, then update the model.
  task automatic applyStimulus(input bit v, input bit sof, input int pix, input bit rdy,
                               input bit rs, output bit acc);
    bit   exp_ready;
    bit   emit;
    int   rr, cc;
    exp_t e;
    bus.pix_valid = v;
    bus.pix_sof   = sof;
    bus.pix_in    = PW'(pix);
    bus.win_ready = rdy;
    rst           = rs;
    @(negedge clk);
    exp_ready = (q.size() == 0) || rdy;
    checkOutput("win_valid", int'(bus.win_valid), int'(q.size() != 0));
    checkOutput("pix_ready", int'(bus.pix_ready), int'(exp_ready));
    if (bus.win_valid && q.size() != 0) begin
      e = q[0];
      for (int t = 0; t < 9; t++)
        checkOutput($sformatf("win%0d@(%0d,%0d)", t, e.r, e.c), dutTap(t), e.tap[t]);
      checkOutput($sformatf("win_last@(%0d,%0d)", e.r, e.c), int'(bus.win_last), int'(e.last));
      if (rdy) begin
        void'(q.pop_front());
        nwin++;
        if (e.last) nlast++;
        for (int t = 0; t < 9; t++) got[e.r][e.c][t] = e.tap[t];
      end
    end
    acc = 1'b0;
    if (rs) begin
      q.delete();
      mr = 0;
      mc = 0;
    end else if (v && exp_ready) begin
      acc = 1'b1;
      if (sof) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = pix;
      for (int t = 0; t < 9; t++) begin
        rr = mr - 2 + t / 3;
        cc = mc - 2 + t % 3;
        e.tap[t] = (rr >= 0 && cc >= 0) ? img[rr][cc] : 0;
      end
      e.last = (mr == IH - 1) && (mc == IW - 1);
      e.r = mr;
      e.c = mc;
`ifdef SOBEL_WIN_INTERIOR_EN
      emit = (mr >= 2) && (mc >= 2);
`else
      emit = 1'b1;
`endif
      if (emit) q.push_back(e);
      if (mc == IW - 1) begin
        mc = 0;
        mr = (mr == IH - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Streams npix pixels with optional sof, 5-cycle stall or reset pulse at given points.
  task automatic runFrame(input int npix, input int sof_k, input int stall_k, input int rst_k,
                          output int cycles);
    int k = 0;
    int cyc = 0;
    int r, c;
    bit rdy, acc;
    nwin = 0;
    nlast = 0;
    for (int i = 0; i < IH; i++)
      for (int j = 0; j < IW; j++)
        for (int t = 0; t < 9; t++) got[i][j][t] = -1;
    while (k < npix && cyc < 200) begin
      r = (k / IW) % IH;
      c = k % IW;
      rdy = !(stall_k >= 0 && cyc > stall_k && cyc <= stall_k + 5);
      applyStimulus(1'b1, k == sof_k, 10 * r + c + 1, rdy, cyc == rst_k, acc);
      if (cyc == rst_k) k = 0;
      else if (acc) k++;
      cyc++;
    end
    cycles = cyc;
    checkOutput("stream_done", int'(k >= npix), 1);
    for (int i = 0; i < 4 && q.size() != 0; i++) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, acc);
    checkOutput("drain", q.size(), 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    doReset();
    checkOutput("rst win_valid", int'(bus.win_valid), 0);
    checkOutput("rst win_last", int'(bus.win_last), 0);
    checkOutput("rst win0", int'(bus.win0), 0);
    checkOutput("rst win4", int'(bus.win4), 0);
    checkOutput("rst win8", int'(bus.win8), 0);
    checkOutput("rst pix_ready", int'(bus.pix_ready), 1);

    $display("[TB] full frame");
    runFrame(16, -1, -1, -1, ncyc);
`ifdef SOBEL_WIN_INTERIOR_EN
    checkOutput("s1 count", nwin, 4);
`else
    checkOutput("s1 count", nwin, 16);
    checkWin("s1 (0,0)", 0, 0, w00);
    checkWin("s1 (1,0)", 1, 0, w10);
`endif
    checkOutput("s1 last count", nlast, 1);
    checkWin("s1 (2,2)", 2, 2, w22);
    checkWin("s1 (3,3)", 3, 3, w33);

    $display("[TB] stall at (2,1)");
    doReset();
    runFrame(16, -1, 9, -1, ncyc);
`ifdef SOBEL_WIN_INTERIOR_EN
    checkOutput("s2 count", nwin, 4);
`else
    checkOutput("s2 count", nwin, 16);
`endif
    checkOutput("s2 last count", nlast, 1);

    $display("[TB] sof at (1,2)");
    doReset();
    runFrame(16, 6, -1, -1, ncyc);
`ifdef SOBEL_WIN_INTERIOR_EN
    checkOutput("s3 count", nwin, 0);
`else
    checkOutput("s3 count", nwin, 16);
    checkWin("s3 (0,0)", 0, 0, s00);
    checkWin("s3 (0,1)", 0, 1, s01);
    checkWin("s3 (1,0)", 1, 0, s10);
`endif

    $display("[TB] reset at (2,3)");
    doReset();
    runFrame(16, -1, -1, 11, ncyc);
`ifdef SOBEL_WIN_INTERIOR_EN
    checkOutput("s4 count", nwin, 5);
`else
    checkOutput("s4 count", nwin, 27);
    checkWin("s4 (0,0)", 0, 0, w00);
`endif
    checkOutput("s4 last count", nlast, 1);

    $display("[TB] two back-to-back frames");
    doReset();
    runFrame(32, -1, -1, -1, ncyc);
    checkOutput("s5 cycles", ncyc, 32);
    checkOutput("s5 last count", nlast, 2);
`ifdef SOBEL_WIN_INTERIOR_EN
    checkOutput("s5 count", nwin, 8);
`else
    checkOutput("s5 count", nwin, 32);
    checkWin("s5 frame2 (0,1)", 0, 1, f01);
`endif
    checkWin("s5 frame2 (2,2)", 2, 2, w22);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
